// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master types and mode constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_HI,
        PRE_LO,
        SETUP,
        BIT_HI,
        BIT_LO
    } spi_master_state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: emits a one-cycle tick every CLK_DIV sclk cycles, restartable by clr_i.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic sclk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = cnt_q == CW'(CLK_DIV - 1);

    // Count to CLK_DIV-1 then wrap; a clear forces the next phase to start at 0.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_i || tick_o)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator, MSB first; SPI_MASTER_BURST_EN allows back-to-back words under one cs_n.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             spi_clk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = $clog2(WIDTH);

    spi_master_state_t state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic             spi_clk_q, spi_clk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
    logic             tick, last, fin, accept, clr;

    assign clr = state_d != state_q;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .sclk  (sclk),
        .rst   (rst),
        .clr_i (clr),
        .tick_o(tick)
    );

    assign last = bit_q == BW'(WIDTH - 1);
    assign fin  = (state_q == BIT_LO) && tick && last;

`ifdef SPI_MASTER_BURST_EN
    assign ready = (state_q == IDLE) || fin;
`else
    assign ready = state_q == IDLE;
`endif

    assign busy    = !ready;
    assign accept  = start && ready;
    assign done    = fin;
    assign dout    = fin ? rx_q : dout_q;
    assign spi_clk = spi_clk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

    // State register.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath and registered SPI pins.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            spi_clk_q <= SPI_CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            spi_clk_q <= spi_clk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    // Phase sequencing: each phase lasts one divider period; pins are set on phase entry.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = fin ? rx_q : dout_q;
        spi_clk_d = spi_clk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d   = PRE_HI;
                spi_clk_d = 1'b1;
                cs_n_d    = 1'b1;
                tx_d      = din;
                bit_d     = '0;
            end
            PRE_HI: if (tick) begin
                state_d   = PRE_LO;
                spi_clk_d = 1'b0;
            end
            PRE_LO: if (tick) begin
                state_d = SETUP;
                cs_n_d  = 1'b0;
                mosi_d  = tx_q[WIDTH-1];
            end
            SETUP: if (tick) begin
                state_d   = BIT_HI;
                spi_clk_d = 1'b1;
            end
            BIT_HI: if (tick) begin
                state_d   = BIT_LO;
                spi_clk_d = 1'b0;
                rx_d      = {rx_q[WIDTH-2:0], miso};
                tx_d      = tx_q << 1;
                mosi_d    = last ? 1'b0 : tx_q[WIDTH-2];
            end
            BIT_LO: if (tick) begin
                if (!last) begin
                    state_d   = BIT_HI;
                    spi_clk_d = 1'b1;
                    bit_d     = bit_q + 1'b1;
                end else if (accept) begin
                    state_d   = BIT_HI;
                    spi_clk_d = 1'b1;
                    bit_d     = '0;
                    tx_d      = din;
                    mosi_d    = din[WIDTH-1];
                end else begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 initiator: the controller end of the link served by the team's SPI slave.
- Runs on the system clock and generates spi_clk, cs_n and mosi itself; samples miso.
- Word-oriented, MSB first; start/ready handshake on the user side, done pulse carrying the received word.
- Drives one slave directly (e.g. the VGA_SPI core from a test or host-side FPGA).

Parameters:
- WIDTH, 8, bits per word; must be >= 2.
- CLK_DIV, 2, spi_clk half-period in sclk cycles (H); must be >= 1.

Ports:
- sclk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; accepted when start && ready at a posedge.
- din  input  WIDTH  word to transmit; captured on the accept cycle.
- ready  output  1  high in IDLE only.
- busy  output  1  equals !ready.
- done  output  1  one-cycle pulse when dout is updated.
- dout  output  WIDTH  last received word; held until the next done.
- spi_clk  output  1  SPI clock, idle low (CPOL=0).
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, spi_clk=0, cs_n=1, mosi=0, done=0, dout=0, ready=1.
  - Reset mid-transfer aborts immediately; no done pulse is issued.
- Divider: a counter with $clog2(CLK_DIV)+1 bits produces a phase tick every H cycles. The counter is cleared on accept and restarts at 0 on every state change.
- Transfer, with accept at cycle T:
  - PRE_HI (H cycles): cs_n=1, spi_clk=1. Its falling edge makes the slave load its own din while still deselected.
  - PRE_LO (H cycles): cs_n=1, spi_clk=0.
  - SETUP (H cycles): cs_n=0, spi_clk=0, mosi=din[WIDTH-1].
  - BIT_HI (H cycles): spi_clk=1. miso is shifted into the rx register in the last sclk cycle of the phase.
  - BIT_LO (H cycles): spi_clk=0. mosi advances to the next lower bit at phase entry; after the last bit mosi=0.
  - BIT_HI/BIT_LO repeat WIDTH times; the bit counter runs 0..WIDTH-1 with no wrap beyond it.
  - After the last BIT_LO: cs_n=1, done=1, dout=rx, state=IDLE.
- Timing:
  - done and the cs_n rise occur at cycle T+(2*WIDTH+3)*H.
  - ready=1 from T+(2*WIDTH+3)*H+1.
  - WIDTH=8, H=2: done at T+38.
- start while busy is ignored (unless the optional feature applies).
- din changes after accept have no effect on the transfer in flight.
- spi_clk, cs_n and mosi are registered outputs; no combinational path from any input to them.

Optional Feature:
- Macro SPI_MASTER_BURST_EN.
- When defined:
  - If start=1 in the last sclk cycle of the final BIT_LO, a new din is accepted in that cycle.
  - done pulses for the completed word in that same cycle.
  - cs_n stays 0; PRE_HI, PRE_LO and SETUP are skipped.
  - mosi=new din[WIDTH-1] in that cycle; BIT_HI of bit 0 follows.
  - ready is 1 only in that cycle while busy.
  - The slave does not reload mid-burst: miso is whatever the slave shifts, and the master samples it unmodified.
- When undefined: the first bullet above does not apply; the transfer ends as described in Behaviour.

Decomposition:
- Package spi_pkg holds:
  - typedef enum spi_master_state_t {IDLE, PRE_HI, PRE_LO, SETUP, BIT_HI, BIT_LO}.
  - SPI_CPOL=0 and SPI_CPHA=0 localparams, shared with the slave bench.
- Sub-module spi_clk_div: parameterised half-period tick generator with sync clear input.

Test Plan (WIDTH=8, CLK_DIV=2, loopback to spi_slave whose din=8'h3C):
1. start with din=8'hA5 -> mosi bits 1,0,1,0,0,1,0,1 at the spi_clk rises; slave d_valid with dout=8'hA5; master done at T+38 with dout=8'h3C; cs_n low for exactly 34 cycles.
2. CLK_DIV=1, din=8'hFF, slave din=8'h00 -> done at T+19, dout=8'h00; spi_clk period 2 cycles.
3. start held high with din=8'h81 for 100 cycles -> no burst (macro undefined): two transfers; cs_n high for at least 2H+1 cycles between them (includes the preload pulse); both dout=8'h3C.
4. rst asserted at T+20 -> cs_n=1, spi_clk=0, ready=1 same cycle; no done; the next transfer with 8'h5A completes normally.
5. start pulsed during busy (cycle T+10) -> ignored; exactly one done.
6. SPI_MASTER_BURST_EN defined, start held with din 8'h12 then 8'h34 -> cs_n low continuously across both words; slave outputs 12 then 34; done pulses at T+38 and T+70.
